// File: rtl/vsa_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and
// default address/data widths.
package vsa_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/vsa_rr_pick2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the
// port named by ptr. Output is one-hot, or zero when nothing is requested.
module vsa_rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/vsa_mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// One access per two cycles: ACCESS drives the memory, RESP returns the result.
module vsa_mem_arbiter
  import vsa_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    state;
  logic          ptr;
  logic          lat_idx;
  logic          lat_wr;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [1:0]    pick;
  logic          in_access;
  logic          in_resp;

  vsa_rr_pick2 u_pick (
    .req (({req1, req0})),
    .ptr (ptr),
    .gnt (pick)
  );

  // Requests are only looked at outside ACCESS, so a requester's stale level
  // during its own grant cycle never turns into a second access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      lat_idx   <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        ST_ACCESS: state <= ST_RESP;
        default: begin
          if (|pick) begin
            state     <= ST_ACCESS;
            lat_idx   <= pick[1];
            lat_wr    <= pick[1] ? wr1 : wr0;
            lat_addr  <= pick[1] ? addr1 : addr0;
            lat_wdata <= pick[1] ? wdata1 : wdata0;
            ptr       <= ~pick[1];
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    in_access = (state == ST_ACCESS);
    in_resp   = (state == ST_RESP);
    mem_en    = in_access;
    mem_wr    = in_access & lat_wr;
    mem_addr  = in_access ? lat_addr : '0;
    mem_wdata = in_access ? lat_wdata : '0;
    gnt0      = in_access & ~lat_idx;
    gnt1      = in_access & lat_idx;
    rvalid0   = in_resp & ~lat_idx;
    rvalid1   = in_resp & lat_idx;
    rdata0    = rvalid0 ? mem_rdata : '0;
    rdata1    = rvalid1 ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_vsa_mem_arbiter.sv
// Bench for vsa_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_vsa_mem_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 5;
  localparam int unsigned MD = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          wr0 = 1'b0, wr1 = 1'b0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clock = ~clock;

  vsa_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wr0(wr0), .wr1(wr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous-read memory attached to the DUT's memory port.
  logic [DW-1:0] memory [MD];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wr) memory[mem_addr] = mem_wdata;
      else        mem_rdata <= memory[mem_addr];
    end
  end

  // Transaction model: a cycle right after a grant is its completion cycle;
  // every other cycle arbitrates the requests present at its closing edge.
  logic [DW-1:0] ref_mem [MD];
  logic          g_v = 0, g_idx = 0, g_wr = 0, m_ptr = 0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0;
  logic          r_v = 0, r_idx = 0, r_rd = 0;
  logic [DW-1:0] r_data = '0;

  always @(posedge clock or posedge reset) begin
    logic win;
    if (reset) begin
      g_v = 0; g_idx = 0; g_wr = 0; g_addr = '0; g_wdata = '0;
      r_v = 0; r_idx = 0; r_rd = 0; m_ptr = 0;
    end else begin
      r_v = 0;
      if (g_v) begin
        r_v = 1; r_idx = g_idx; r_rd = !g_wr;
        if (g_wr) ref_mem[g_addr] = g_wdata;
        else      r_data = ref_mem[g_addr];
        g_v = 0;
      end else if (req0 || req1) begin
        win     = (req0 && req1) ? m_ptr : req1;
        g_v     = 1;
        g_idx   = win;
        g_wr    = win ? wr1 : wr0;
        g_addr  = win ? addr1 : addr0;
        g_wdata = win ? wdata1 : wdata0;
        m_ptr   = !win;
      end
    end
  end

  always @(negedge clock) begin
    logic [1:0] exp_g, exp_r;
    exp_g = {g_v && g_idx, g_v && !g_idx};
    exp_r = {r_v && r_idx, r_v && !r_idx};
    check("gnt", 32'({gnt1, gnt0}), 32'(exp_g));
    check("rvalid", 32'({rvalid1, rvalid0}), 32'(exp_r));
    check("rdata0", 32'(rdata0), exp_r[0] ? 32'(mem_rdata) : 32'd0);
    check("rdata1", 32'(rdata1), exp_r[1] ? 32'(mem_rdata) : 32'd0);
    check("mem_bus", 32'({mem_en, mem_wr, mem_addr, mem_wdata}),
          g_v ? 32'({1'b1, g_wr, g_addr, g_wdata}) : 32'd0);
    if (r_v && r_rd) check("read_data", 32'(mem_rdata), 32'(r_data));
  end

  task automatic apply_reset();
    @(negedge clock); #2;
    reset = 1; req0 = 0; req1 = 0;
    @(negedge clock); @(negedge clock);
  endtask

  task automatic next_req(input logic cur, input logic granted, output logic nreq, output logic fresh);
    if (cur && granted) begin
      nreq = ($urandom_range(0, 1) == 1); fresh = nreq;
    end else if (cur) begin
      nreq = ($urandom_range(0, 15) != 0); fresh = 0;
    end else begin
      nreq = ($urandom_range(0, 2) != 0); fresh = nreq;
    end
  endtask

  initial begin
    logic n0, n1, f0, f1;
    for (int unsigned i = 0; i < MD; i++) begin
      memory[i]  = DW'($urandom);
      ref_mem[i] = memory[i];
    end
    #1 reset = 1;

    // Single read: grant and memory strobe in cycle 1, data back in cycle 2.
    apply_reset();
    memory[6] = 5'd19; ref_mem[6] = 5'd19;
    req0 = 1; addr0 = 5'd6; wr0 = 0; wdata0 = '0;
    reset = 0;
    @(negedge clock);
    check("t1_mem_en_addr", 32'({mem_en, mem_addr}), 32'({1'b1, 5'd6}));
    check("t1_gnt0", 32'({gnt1, gnt0}), 32'd1);
    req0 = 0;
    @(negedge clock);
    check("t1_rvalid0", 32'({rvalid1, rvalid0}), 32'd1);
    check("t1_rdata0", 32'(rdata0), 32'd19);

    // Both requesting continuously: alternate 0,1,0,1 every second cycle.
    apply_reset();
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 5'd1; addr1 = 5'd2;
    reset = 0;
    for (int c = 1; c <= 8; c++) begin
      logic [1:0] e;
      @(negedge clock);
      e = (c % 4 == 1) ? 2'b01 : (c % 4 == 3) ? 2'b10 : 2'b00;
      check("t2_rr_order", 32'({gnt1, gnt0}), 32'(e));
    end
    req0 = 0; req1 = 0;

    // Write from port 1.
    apply_reset();
    req1 = 1; wr1 = 1; addr1 = 5'd30; wdata1 = 5'd21;
    reset = 0;
    @(negedge clock);
    check("t3_write_bus", 32'({mem_en, mem_wr, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 5'd30, 5'd21}));
    check("t3_gnt1", 32'({gnt1, gnt0}), 32'd2);
    req1 = 0;
    @(negedge clock);
    check("t3_rvalid1", 32'({rvalid1, rvalid0, mem_en}), 32'b100);

    // Port 1 alone, three back-to-back accesses.
    apply_reset();
    req1 = 1; wr1 = 0; addr1 = 5'd3;
    reset = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      check("t4_gnt1_cadence", 32'({gnt1, gnt0}), (c % 2 == 1) ? 32'd2 : 32'd0);
      if (c == 5) req1 = 0;
    end

    // Reset during ACCESS abandons the access and restores pointer to port 0.
    apply_reset();
    req0 = 1; wr0 = 0; addr0 = 5'd9;
    reset = 0;
    @(negedge clock);
    check("t5_gnt0_before", 32'({gnt1, gnt0}), 32'd1);
    #2 reset = 1;
    #1 check("t5_async_clear", 32'({mem_en, gnt1, gnt0}), 32'd0);
    req0 = 0;
    @(negedge clock); @(negedge clock);
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("t5_no_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    end
    req0 = 1; req1 = 1; addr1 = 5'd4; wr1 = 0;
    @(negedge clock);
    check("t5_ptr_port0", 32'({gnt1, gnt0}), 32'd1);
    req0 = 0;
    @(negedge clock); @(negedge clock);
    req1 = 0;

    // A one-cycle req0 during port 1's ACCESS is never sampled.
    apply_reset();
    req1 = 1; wr1 = 0; addr1 = 5'd7;
    reset = 0;
    @(negedge clock);
    req1 = 0; req0 = 1; addr0 = 5'd8; wr0 = 0;
    @(negedge clock);
    req0 = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("t6_no_gnt0", 32'(gnt0), 32'd0);
    end

    // Randomized traffic with occasional asynchronous resets.
    apply_reset();
    reset = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      next_req(req0, gnt0, n0, f0);
      next_req(req1, gnt1, n1, f1);
      req0 = n0; req1 = n1;
      if (f0) begin addr0 = AW'($urandom); wr0 = 1'($urandom); wdata0 = DW'($urandom); end
      if (f1) begin addr1 = AW'($urandom); wr1 = 1'($urandom); wdata1 = DW'($urandom); end
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1;
        @(negedge clock);
        reset = 0;
      end
    end

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
